alu_ctrl: RTL

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl_pkg.sv | 91 +++++++++
 rtl/alu_ctrl_regfile.sv | 36 +++
 rtl/alu_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types, instruction field layout and opcode helpers for the ALU
// controller and its register file.
package alu_ctrl_pkg;

    localparam int DATA_W   = 4;
    localparam int REG_AW   = 3;
    localparam int NUM_REGS = 8;
    localparam int INSTR_W  = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RA_MSB  = 10;
    localparam int RA_LSB  = 8;
    localparam int RB_MSB  = 6;
    localparam int RB_LSB  = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_AND = 4'b0011,
        OP_OR  = 4'b0100,
        OP_XOR = 4'b0101,
        OP_MOV = 4'b0110,
        OP_RSH = 4'b0111,
        OP_LSH = 4'b1000,
        OP_LDI = 4'b1001,
        OP_ADI = 4'b1010,
        OP_CMP = 4'b1101
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]        opcode;
        logic [REG_AW-1:0] ra;
        logic [REG_AW-1:0] rb;
        logic [DATA_W-1:0] imm;
    } instr_fields_t;

    function automatic instr_fields_t decode_instr(input logic [INSTR_W-1:0] word);
        instr_fields_t f;
        f.opcode = word[OPC_MSB:OPC_LSB];
        f.ra     = word[RA_MSB:RA_LSB];
        f.rb     = word[RB_MSB:RB_LSB];
        f.imm    = word[IMM_MSB:IMM_LSB];
        return f;
    endfunction

    function automatic logic op_writes_back(input logic [3:0] opcode);
        logic wb;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_MOV, OP_RSH, OP_LSH, OP_LDI, OP_ADI: wb = 1'b1;
            default:                                wb = 1'b0;
        endcase
        return wb;
    endfunction

    // CMP updates flags like a subtract but never touches the register file.
    function automatic logic op_sets_flags(input logic [3:0] opcode);
        return op_writes_back(opcode) || (opcode == OP_CMP);
    endfunction

    function automatic logic op_uses_imm(input logic [3:0] opcode);
        return (opcode == OP_LDI) || (opcode == OP_ADI);
    endfunction

    function automatic logic op_carry(input logic [3:0]        opcode,
                                      input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
        logic [DATA_W:0] sum;
        logic            c;
        sum = {1'b0, a} + {1'b0, b};
        case (opcode)
            OP_ADD, OP_ADI: c = sum[DATA_W];
            OP_SUB, OP_CMP: c = (a < b);
            OP_RSH:         c = a[0];
            OP_LSH:         c = a[DATA_W-1];
            default:        c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// 8x4 register file: one synchronous write port, two combinational operand
// read ports and a combinational debug read port.
module ctrl_regfile
    import alu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // No write-through: a write only becomes visible after the clock edge.
    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
    assign dbg_data  = regs[dbg_addr];

endmodule

// File: rtl/alu_ctrl.sv
// Three-phase instruction controller driving an external combinational ALU:
// capture in IDLE, operate in EXEC, retire (writeback + flags) leaving WB.
module alu_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    output logic [3:0]         alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_o,
    output logic               done,
    output logic               flag_z,
    output logic               flag_c,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    state_t            state_q;
    state_t            state_d;
    instr_fields_t     cur_q;
    logic [DATA_W-1:0] result_q;
    logic              carry_q;
    logic              carry_d;
    logic              flag_z_q;
    logic              flag_c_q;
    logic              wr_en;
    logic              flag_en;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              unused_instr_bits;

    assign unused_instr_bits = ^{instr[11], instr[7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus every per-state output; the ALU sees zeros outside EXEC.
    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        done        = 1'b0;
        alu_op      = 4'b0000;
        alu_a       = '0;
        alu_b       = '0;
        wr_en       = 1'b0;
        flag_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op  = (cur_q.opcode == OP_CMP) ? 4'(OP_SUB) : cur_q.opcode;
                alu_a   = rd_data_a;
                alu_b   = op_uses_imm(cur_q.opcode) ? cur_q.imm : rd_data_b;
                state_d = ST_WB;
            end
            ST_WB: begin
                done    = 1'b1;
                wr_en   = op_writes_back(cur_q.opcode);
                flag_en = op_sets_flags(cur_q.opcode);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q <= '0;
        end else if (instr_ready && instr_valid) begin
            cur_q <= decode_instr(instr);
        end
    end

    // Carry is derived from the operands actually presented to the ALU.
    assign carry_d = op_carry(cur_q.opcode, alu_a, alu_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            carry_q  <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            result_q <= alu_o;
            carry_q  <= carry_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (flag_en) begin
            flag_z_q <= (result_q == '0);
            flag_c_q <= carry_q;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;

    ctrl_regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (cur_q.ra),
        .wr_data   (result_q),
        .rd_addr_a (cur_q.ra),
        .rd_data_a (rd_data_a),
        .rd_addr_b (cur_q.rb),
        .rd_data_b (rd_data_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

endmodule
